// File: rtl/sensor_debounce.sv
// Two-channel input conditioner for the car-park beam sensors.
// Each channel has a 2-flop synchroniser, a stability counter and registered edge pulses.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 is the outer beam (a), index 1 the inner beam (b).
    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       clean;
    logic [1:0]       clean_nxt;
    logic [1:0]       rise;
    logic [1:0]       rise_nxt;
    logic [1:0]       fall;
    logic [1:0]       fall_nxt;
    logic [CNT_W-1:0] cnt     [2];
    logic [CNT_W-1:0] cnt_nxt [2];
    state_t           state   [2];

    assign raw = {b_raw, a_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State is whether the synchronised level disagrees with the clean output.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state[i]     = (s2[i] != clean[i]) ? PENDING : STABLE;
            cnt_nxt[i]   = '0;
            clean_nxt[i] = clean[i];
            rise_nxt[i]  = 1'b0;
            fall_nxt[i]  = 1'b0;
            case (state[i])
                STABLE: begin
                    cnt_nxt[i] = '0;
                end
                PENDING: begin
                    if (cnt[i] == TERM) begin
                        clean_nxt[i] = s2[i];
                        rise_nxt[i]  = s2[i];
                        fall_nxt[i]  = ~s2[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
            clean  <= '0;
            rise   <= '0;
            fall   <= '0;
        end else begin
            cnt[0] <= cnt_nxt[0];
            cnt[1] <= cnt_nxt[1];
            clean  <= clean_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
        end
    end

    assign a      = clean[0];
    assign b      = clean[1];
    assign a_rise = rise[0];
    assign a_fall = fall[0];
    assign b_rise = rise[1];
    assign b_fall = fall[1];

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: directed scenarios plus random bouncing inputs,
// compared every cycle against a history-window reference model.
module tb_sensor_debounce;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a_raw = 1'b0;
    logic b_raw = 1'b0;
    logic a, b, a_rise, a_fall, b_rise, b_fall;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .a_raw  (a_raw),
        .b_raw  (b_raw),
        .a      (a),
        .b      (b),
        .a_rise (a_rise),
        .a_fall (a_fall),
        .b_rise (b_rise),
        .b_fall (b_fall)
    );

    always #5 clk = ~clk;

    // Reference model: every raw sample taken since reset, and the synchronised
    // value seen before each edge (raw delayed two samples). A channel's clean
    // level flips when the last D synchronised values all differ from it and
    // none of them predates the previous flip.
    logic [1:0] rawhist [$];
    logic [1:0] s2hist  [$];
    int         last_chg [2];
    logic       exp_lvl  [2];
    logic       exp_rise [2];
    logic       exp_fall [2];

    int pa_r, pa_f, pb_r, pb_f, both_r, both_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        rawhist.delete();
        s2hist.delete();
        for (int c = 0; c < 2; c++) begin
            last_chg[c] = -1;
            exp_lvl[c]  = 1'b0;
            exp_rise[c] = 1'b0;
            exp_fall[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int         e;
        logic [1:0] s2v;
        bit         all_diff;
        if (!reset) begin
            model_clear();
            return;
        end
        e   = rawhist.size();
        s2v = (e >= 2) ? rawhist[e-2] : 2'b00;
        s2hist.push_back(s2v);
        rawhist.push_back({b_raw, a_raw});
        for (int c = 0; c < 2; c++) begin
            exp_rise[c] = 1'b0;
            exp_fall[c] = 1'b0;
            if (e - last_chg[c] >= D) begin
                all_diff = 1'b1;
                for (int j = e - D + 1; j <= e; j++)
                    if (s2hist[j][c] == exp_lvl[c]) all_diff = 1'b0;
                if (all_diff) begin
                    exp_lvl[c]  = ~exp_lvl[c];
                    exp_rise[c] = exp_lvl[c];
                    exp_fall[c] = ~exp_lvl[c];
                    last_chg[c] = e;
                end
            end
        end
    endtask

    task automatic clear_tally();
        pa_r = 0; pa_f = 0; pb_r = 0; pb_f = 0; both_r = 0; both_f = 0;
    endtask

    // One clock: drive raw inputs, advance the model at the edge, compare #1 later.
    task automatic step(input logic ra, input logic rb);
        a_raw = ra;
        b_raw = rb;
        @(posedge clk);
        model_edge();
        #1;
        check("a",        a,      exp_lvl[0]);
        check("b",        b,      exp_lvl[1]);
        check("a_rise",   a_rise, exp_rise[0]);
        check("a_fall",   a_fall, exp_fall[0]);
        check("b_rise",   b_rise, exp_rise[1]);
        check("b_fall",   b_fall, exp_fall[1]);
        check("a_excl",   a_rise & a_fall, 0);
        check("b_excl",   b_rise & b_fall, 0);
        pa_r   += a_rise;
        pa_f   += a_fall;
        pb_r   += b_rise;
        pb_f   += b_fall;
        both_r += (a_rise & b_rise);
        both_f += (a_fall & b_fall);
        @(negedge clk);
    endtask

    // Holds the inputs for up to 12 edges and reports the first edge at which a==want.
    task automatic edges_to_a(input logic ra, input logic rb, input logic want,
                              output int n, output logic pulse_at, output logic pulse_after);
        n = -1;
        pulse_at = 1'b0;
        pulse_after = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(ra, rb);
            if (n > 0 && i == n + 1) pulse_after = want ? a_rise : a_fall;
            if (n < 0 && a == want) begin
                n = i;
                pulse_at = want ? a_rise : a_fall;
            end
        end
    endtask

    task automatic settle(input logic ra, input logic rb);
        for (int i = 0; i < 10; i++) step(ra, rb);
    endtask

    initial begin
        int   n;
        logic p_at, p_after;
        model_clear();
        @(negedge clk);

        // 1: reset held with inputs high, then released
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        reset = 1'b1;
        edges_to_a(1'b1, 1'b1, 1'b1, n, p_at, p_after);
        check("rel_latency", n, 6);
        check("rel_rise", p_at, 1);
        check("rel_rise_once", p_after, 0);

        // 2: clean step on a with b held low
        settle(1'b0, 1'b0);
        clear_tally();
        edges_to_a(1'b1, 1'b0, 1'b1, n, p_at, p_after);
        check("step_latency", n, 6);
        check("step_rise", p_at, 1);
        check("step_rise_end", p_after, 0);
        check("step_b_quiet", pb_r + pb_f, 0);
        settle(1'b0, 1'b0);

        // 3: three-cycle glitch rejected, four-cycle pulse accepted
        clear_tally();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
        check("glitch_a", a, 0);
        check("glitch_pulses", pa_r + pa_f, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("accept_rise", pa_r, 1);
        settle(1'b0, 1'b0);

        // 4: bouncing then settling high
        clear_tally();
        for (int i = 0; i < 20; i++) step(i[0] ? 1'b0 : 1'b1, 1'b0);
        check("bounce_pulses", pa_r + pa_f, 0);
        check("bounce_a", a, 0);
        edges_to_a(1'b1, 1'b0, 1'b1, n, p_at, p_after);
        check("bounce_latency", n, 6);
        check("bounce_rise_cnt", pa_r, 1);
        settle(1'b0, 1'b0);

        // 5: simultaneous rise and fall on both channels
        clear_tally();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        check("sim_both_rise", both_r, 1);
        check("sim_both_fall", both_f, 1);
        check("sim_a_pulses", pa_r + pa_f, 2);
        check("sim_b_pulses", pb_r + pb_f, 2);

        // 6: reset while a fall is pending, then release with a_raw high
        settle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("pre_rst_a", a, 1);
        a_raw = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_clear();
        check("async_rst_a", a, 0);
        check("async_rst_rise", a_rise, 0);
        @(negedge clk);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset = 1'b1;
        edges_to_a(1'b1, 1'b0, 1'b1, n, p_at, p_after);
        check("midrst_latency", n, 6);

        // Random bouncing on both channels with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            logic ra, rb;
            int   len;
            ra  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                #1;
                model_clear();
                check("rnd_rst_a", a, 0);
                check("rnd_rst_b", b, 0);
                @(negedge clk);
                step(ra, rb);
                reset = 1'b1;
            end
            for (int i = 0; i < len; i++) step(ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
